// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state enum, instruction field bounds and result flag indices for alu_issue_queue
package alu_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 16;
  localparam int A_MSB = 15;
  localparam int A_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 0;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x W FIFO; ports clk, rst (async high), push (ignored when full), pop (never when empty), din, dout (head, combinational), full, empty, count
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: FIFO-buffered issuer; host in_valid/in_ready/in_instr, registered instr_out to Control_Unit, alu_out/alu_carry/alu_overflow/alu_zero captured into res_valid/res_ready/res_data/res_flags/res_opcode, count/busy status; stat_issued/stat_zero exist only with ALU_ISSUE_STATS_EN
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int INSTR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic [INSTR_W-1:0]       instr_out,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic                     alu_carry,
  input  logic                     alu_overflow,
  input  logic                     alu_zero,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic [2:0]               res_flags,
  output logic [3:0]               res_opcode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]              stat_issued,
  output logic [15:0]              stat_zero
`endif
);
  state_t state, state_nx;
  logic pop, empty, full;
  logic [INSTR_W-1:0] head;
  sync_fifo #(.W(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(in_valid), .pop(pop), .din(in_instr),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign in_ready = !full;
  assign busy = state != IDLE || count != '0;
  // res_valid is high only in HOLD, so a HOLD handshake is simply res_ready there
  always_comb begin
    pop = !empty && (state == IDLE || (state == HOLD && res_ready));
    state_nx = state == EXEC ? HOLD : pop ? EXEC : (state == HOLD && res_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      instr_out <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_flags <= '0;
      res_opcode <= '0;
    end else begin
      state <= state_nx;
      if (pop) instr_out <= head;
      if (state == EXEC) begin
        res_valid <= 1'b1;
        res_data <= alu_out;
        res_flags[FLG_C] <= alu_carry;
        res_flags[FLG_V] <= alu_overflow;
        res_flags[FLG_Z] <= alu_zero;
        res_opcode <= instr_out[OPC_MSB:OPC_LSB];
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_issued <= '0;
      stat_zero <= '0;
    end else if (state == EXEC) begin
      stat_issued <= stat_issued + 16'd1;
      stat_zero <= stat_zero + 16'(alu_zero);
    end
`endif
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: vector table, fill/stream/random-stall/reset sequences checked against a queue-based reference model
module tb_alu_issue_queue;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, res_valid, res_ready = 0, busy;
  logic alu_carry, alu_overflow, alu_zero;
  logic [19:0] in_instr = '0, instr_out;
  logic [7:0] alu_out, res_data;
  logic [2:0] res_flags;
  logic [3:0] res_opcode, count;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_issued, stat_zero;
`endif
  int tests = 0, fails = 0, cyc = 0;
  logic [14:0] q[$];
  int hs_times[$];

  alu_issue_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .instr_out(instr_out), .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_opcode(res_opcode), .count(count), .busy(busy)
`ifdef ALU_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_zero(stat_zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Control_Unit stand-in: returns {carry, overflow, zero, result}
  function automatic logic [10:0] cu(input logic [19:0] ins);
    logic [7:0] a, b;
    logic [8:0] s;
    logic v;
    a = ins[15:8];
    b = ins[7:0];
    v = 1'b0;
    case (ins[19:16])
      4'd0: begin s = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (s[7] != a[7]); end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (s[7] != a[7]); end
      4'd2: s = {1'b0, a & b};
      4'd3: s = {1'b0, a | b};
      4'd4: s = {1'b0, a ^ b};
      default: s = {1'b0, a};
    endcase
    return {s[8], v, s[7:0] == 8'd0, s[7:0]};
  endfunction

  assign {alu_carry, alu_overflow, alu_zero, alu_out} = cu(instr_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every accepted push enqueues its expected result; every cycle a result is shown it must match the head
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (res_valid) begin
        if (q.size() == 0) chk("res_spurious", 32'(res_valid), 32'd0);
        else begin
          chk("res_model", {17'd0, res_opcode, res_flags, res_data}, {17'd0, q[0]});
          if (res_ready) begin
            void'(q.pop_front());
            hs_times.push_back(cyc);
          end
        end
      end
      if (in_valid && in_ready) q.push_back({in_instr[19:16], cu(in_instr)});
    end
  end

  task automatic push(input logic [19:0] ins);
    int g;
    logic ok;
    g = 0;
    in_valid = 1;
    in_instr = ins;
    do begin
      ok = in_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!ok && g < 200);
    in_valid = 0;
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    res_ready = 1;
    while ((q.size() != 0 || busy) && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_done", 32'(g < 300), 32'd1);
    res_ready = 0;
  endtask

  task automatic run_vec(input logic [19:0] ins, input logic [3:0] opc, input logic [7:0] d, input logic [2:0] f);
    push(ins);
    @(posedge clk); #1;
    chk("vec_instr_out", 32'(instr_out), 32'(ins));
    chk("vec_not_yet_valid", 32'(res_valid), 32'd0);
    chk("vec_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("vec_valid", 32'(res_valid), 32'd1);
    chk("vec_result", {17'd0, res_opcode, res_flags, res_data}, {17'd0, opc, f, d});
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    chk("vec_released", 32'(res_valid), 32'd0);
    chk("vec_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {logic [19:0] ins; logic [3:0] opc; logic [7:0] d; logic [2:0] f;} vec_t;
  vec_t tv[11];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{20'h10503, 4'h1, 8'h02, 3'b000};
    tv[1]  = '{20'h00503, 4'h0, 8'h08, 3'b000};
    tv[2]  = '{20'h10303, 4'h1, 8'h00, 3'b001};
    tv[3]  = '{20'h0FF01, 4'h0, 8'h00, 3'b101};
    tv[4]  = '{20'h07F01, 4'h0, 8'h80, 3'b010};
    tv[5]  = '{20'h10001, 4'h1, 8'hFF, 3'b100};
    tv[6]  = '{20'h18001, 4'h1, 8'h7F, 3'b010};
    tv[7]  = '{20'h2F00F, 4'h2, 8'h00, 3'b001};
    tv[8]  = '{20'h3F00F, 4'h3, 8'hFF, 3'b000};
    tv[9]  = '{20'h4AAAA, 4'h4, 8'h00, 3'b001};
    tv[10] = '{20'h95A00, 4'h9, 8'h5A, 3'b000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_instr_out", 32'(instr_out), 32'd0);
    chk("rst_res", {21'd0, res_opcode, res_flags, res_data}, 32'd0);
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) run_vec(tv[i].ins, tv[i].opc, tv[i].d, tv[i].f);

    for (int i = 0; i < 8; i++) push(20'($urandom));
    chk("fill_count_peak", 32'(count), 32'd7);
    chk("fill_ready_before_full", 32'(in_ready), 32'd1);
    push(20'($urandom));
    chk("fill_count_full", 32'(count), 32'd8);
    chk("fill_ready_full", 32'(in_ready), 32'd0);
    in_valid = 1;
    in_instr = 20'hABCDE;
    repeat (3) begin
      @(posedge clk); #1;
      chk("full_push_ignored", 32'(count), 32'd8);
    end
    in_valid = 0;
    drain();

    hs_times.delete();
    res_ready = 1;
    for (int i = 0; i < 20; i++) push(20'($urandom));
    drain();
    chk("stream_count", 32'(hs_times.size()), 32'd20);
    chk("stream_span", hs_times.size() == 20 ? 32'(hs_times[19] - hs_times[0]) : 32'hFFFF_FFFF, 32'd38);

    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push(20'($urandom));
        end
      end
      begin
        for (int k = 0; k < 300; k++) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    for (int i = 0; i < 4; i++) push(20'($urandom));
    chk("pre_rst_hold", 32'(res_valid), 32'd1);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1;
    #1;
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_instr_out", 32'(instr_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    run_vec(tv[4].ins, tv[4].opc, tv[4].d, tv[4].f);

`ifdef ALU_ISSUE_STATS_EN
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("stat_rst", {stat_issued, stat_zero}, 32'd0);
    run_vec(tv[1].ins, tv[1].opc, tv[1].d, tv[1].f);
    run_vec(tv[2].ins, tv[2].opc, tv[2].d, tv[2].f);
    run_vec(tv[4].ins, tv[4].opc, tv[4].d, tv[4].f);
    run_vec(tv[7].ins, tv[7].opc, tv[7].d, tv[7].f);
    run_vec(tv[8].ins, tv[8].opc, tv[8].d, tv[8].f);
    chk("stat_issued", 32'(stat_issued), 32'd5);
    chk("stat_zero", 32'(stat_zero), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
